// File: rtl/step_pulse_gen_if.sv
// Signal bundle for step_pulse_gen: step requests and phase settings in,
// stretched step pulse and status out. clock and reset_n are not part of it.
interface step_pulse_gen_if #(
  parameter int HIGH_BITS = 8,
  parameter int LOW_BITS  = 8,
  parameter int PEND_BITS = 4
);

  logic                 enable;
  logic                 advance;
  logic [HIGH_BITS-1:0] high_cycles;
  logic [LOW_BITS-1:0]  low_cycles;
  logic                 overflow_clr;
  logic                 step_out;
  logic                 busy;
  logic [PEND_BITS-1:0] pending;
  logic                 overflow;

  // Requester side: drives requests and settings, observes the pulse.
  modport master (
    output enable,
    output advance,
    output high_cycles,
    output low_cycles,
    output overflow_clr,
    input  step_out,
    input  busy,
    input  pending,
    input  overflow
  );

  // Generator side.
  modport slave (
    input  enable,
    input  advance,
    input  high_cycles,
    input  low_cycles,
    input  overflow_clr,
    output step_out,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns single-cycle step requests into stretched pulses.
// Requests are counted in a saturating pending counter; an IDLE/HIGH/LOW
// machine plays them out with high_cycles high and at least low_cycles low
// (a setting of zero counts as one clock). Settings are captured only when
// the phase counter is loaded.
// Optional feature: define STEP_PULSE_GEN_OVERFLOW_FLAG_EN to build the
// sticky overflow flag; without it overflow is tied to 0 and overflow_clr
// is ignored (requests at saturation are still dropped).
module step_pulse_gen #(
  parameter int HIGH_BITS = 8,
  parameter int LOW_BITS  = 8,
  parameter int PEND_BITS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  step_pulse_gen_if.slave  bus
);

  localparam int CNT_BITS = (HIGH_BITS > LOW_BITS) ? HIGH_BITS : LOW_BITS;
  localparam logic [CNT_BITS-1:0]  CNT_ZERO  = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);
  localparam logic [PEND_BITS-1:0] PEND_ZERO = {PEND_BITS{1'b0}};
  localparam logic [PEND_BITS-1:0] PEND_ONE  = PEND_BITS'(1);
  localparam logic [PEND_BITS-1:0] PEND_MAX  = {PEND_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [PEND_BITS-1:0] pending_q, pending_d;
  logic                 step_out_q, step_out_d;
  logic                 busy_q, busy_d;

  logic                 accept_s;     // request presented this edge
  logic                 take_s;       // FSM starts a pulse this edge
  logic                 drop_s;       // request lost at a saturated count
  logic [CNT_BITS-1:0]  high_load_s;
  logic [CNT_BITS-1:0]  low_load_s;

  // Phase lengths as loaded into the counter; zero is stretched to one clock.
  always_comb begin
    high_load_s = CNT_ZERO;
    low_load_s  = CNT_ZERO;
    if (bus.high_cycles == {HIGH_BITS{1'b0}}) begin
      high_load_s = CNT_ONE;
    end else begin
      high_load_s = CNT_BITS'(bus.high_cycles);
    end
    if (bus.low_cycles == {LOW_BITS{1'b0}}) begin
      low_load_s = CNT_ONE;
    end else begin
      low_load_s = CNT_BITS'(bus.low_cycles);
    end
  end

  // Phase machine: next state, counter load/decrement and pulse start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != PEND_ZERO) begin
          state_d = ST_HIGH;
          cnt_d   = high_load_s;
          take_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        // <= guards an unreachable zero count from wrapping around.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_LOW;
          cnt_d   = low_load_s;
        end else begin
          state_d = ST_HIGH;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q <= CNT_ONE) begin
          if (pending_q != PEND_ZERO) begin
            // Back-to-back: skip IDLE so the period stays high + low.
            state_d = ST_HIGH;
            cnt_d   = high_load_s;
            take_s  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          state_d = ST_LOW;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pending counter: accept and start on one edge cancel, so a full counter
  // keeps the request instead of dropping it.
  always_comb begin
    accept_s  = bus.enable & bus.advance;
    pending_d = pending_q;
    drop_s    = 1'b0;
    if (accept_s && !take_s) begin
      if (pending_q == PEND_MAX) begin
        drop_s    = 1'b1;
        pending_d = pending_q;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (!accept_s && take_s) begin
      pending_d = pending_q - PEND_ONE;
    end else begin
      pending_d = pending_q;
    end
  end

  // Registered outputs are computed from the next state so they line up
  // with the state register and never glitch.
  always_comb begin
    step_out_d = (state_d == ST_HIGH);
    busy_d     = (state_d != ST_IDLE) || (pending_d != PEND_ZERO);
  end

  // State, counter, pending count and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      pending_q  <= PEND_ZERO;
      step_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      step_out_q <= step_out_d;
      busy_q     <= busy_d;
    end
  end

`ifdef STEP_PULSE_GEN_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // Sticky overflow: a drop on the same edge as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  // Flag not built: the clear input and drop indication have no consumer.
  logic unused_ovf_s;
  assign unused_ovf_s = bus.overflow_clr ^ drop_s;
  assign bus.overflow = 1'b0;
`endif

  assign bus.step_out = step_out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios followed by random traffic,
// all compared every cycle against a schedule-based reference model.
module tb_step_pulse_gen;

  localparam int HB   = 4;
  localparam int LB   = 4;
  localparam int PB   = 2;
  localparam int PMAX = (1 << PB) - 1;
  localparam int INF  = 32'h3fff_ffff;

  logic clock;
  logic reset_n;

  step_pulse_gen_if #(.HIGH_BITS(HB), .LOW_BITS(LB), .PEND_BITS(PB)) bus ();

  step_pulse_gen #(.HIGH_BITS(HB), .LOW_BITS(LB), .PEND_BITS(PB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: pulses are a schedule of time windows.
  // m_t  : index of the current edge
  // m_hs : edge that started the latest pulse, m_he : edge its high ends
  // m_nf : earliest edge a new pulse may start (INF while high)
  int m_t, m_hs, m_he, m_nf, m_pend;
  bit m_ovf;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, time %0t)", tag, obs, exp, m_t, $time);
    end
  endtask

  task automatic model_reset();
    m_hs   = -1;
    m_he   = -1;
    m_nf   = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit a, input int hc, input int lc, input bit clr);
    int  h;
    int  l;
    bit  start;
    bit  drop;
    h = (hc == 0) ? 1 : hc;
    l = (lc == 0) ? 1 : lc;
    drop = 1'b0;
    if (m_t == m_he) m_nf = m_t + l;
    start = (m_pend > 0) && (m_t >= m_nf);
    if (start) begin
      m_hs = m_t;
      m_he = m_t + h;
      m_nf = INF;
    end
    if (e && a) begin
      if (start) begin
        // request replaces the one just started
      end else if (m_pend == PMAX) begin
        drop = 1'b1;
      end else begin
        m_pend++;
      end
    end else if (start) begin
      m_pend--;
    end
`ifdef STEP_PULSE_GEN_OVERFLOW_FLAG_EN
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
`else
    if (drop || clr) m_ovf = 1'b0;
`endif
  endtask

  task automatic compare_all();
    check_val("step_out", int'(bus.step_out), int'(m_t >= m_hs && m_t < m_he));
    check_val("pending",  int'(bus.pending),  m_pend);
    check_val("busy",     int'(bus.busy),     int'((m_t < m_nf) || (m_pend != 0)));
    check_val("overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  // One clock: apply inputs, let the edge happen, check half a cycle later.
  task automatic cycle(input bit e, input bit a, input int hc, input int lc, input bit clr);
    bus.enable       = e;
    bus.advance      = a;
    bus.high_cycles  = HB'(hc);
    bus.low_cycles   = LB'(lc);
    bus.overflow_clr = clr;
    @(posedge clock);
    model_edge(e, a, hc, lc, clr);
    @(negedge clock);
    compare_all();
    m_t++;
  endtask

  task automatic idle_cycles(input int n, input int hc, input int lc);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, hc, lc, 1'b0);
  endtask

  initial begin
    int  prob;
    int  hc;
    int  lc;
    bit  e;
    bit  a;
    bit  clr;

    reset_n          = 1'b0;
    bus.enable       = 1'b0;
    bus.advance      = 1'b0;
    bus.high_cycles  = '0;
    bus.low_cycles   = '0;
    bus.overflow_clr = 1'b0;
    m_t = 0;
    model_reset();

    #12;
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;

    // single step, high 3 low 2
    cycle(1'b1, 1'b1, 3, 2, 1'b0);
    idle_cycles(8, 3, 2);

    // burst of three, high 2 low 1
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2, 1, 1'b0);
    idle_cycles(12, 2, 1);

    // zero settings stretch to one clock each
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 0, 0, 1'b0);
    idle_cycles(6, 0, 0);

    // saturation: six requests against a long pulse
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 10, 1, 1'b0);
    idle_cycles(5, 10, 1);
    cycle(1'b1, 1'b0, 10, 1, 1'b1);
    idle_cycles(45, 10, 1);

    // gating: enable low ignores requests, dropping it mid-pulse is harmless
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 6, 2, 1'b0);
    cycle(1'b1, 1'b1, 6, 2, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 6, 2, 1'b0);

    // reset mid-pulse with two requests still pending
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 10, 2, 1'b0);
    idle_cycles(1, 10, 2);
    check_val("pre_reset_pending", int'(bus.pending), 2);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    bus.advance = 1'b0;
    @(posedge clock);
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    idle_cycles(20, 10, 2);

    // first edge after release accepts
    cycle(1'b1, 1'b1, 1, 1, 1'b0);
    idle_cycles(4, 1, 1);

    // random traffic with settings changing every cycle
    prob = 30;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 200) == 0) prob = $urandom_range(5, 90);
      hc  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      lc  = $urandom_range(0, 5);
      e   = ($urandom_range(0, 9) != 0);
      a   = ($urandom_range(1, 100) <= prob);
      clr = ($urandom_range(0, 19) == 0);
      cycle(e, a, hc, lc, clr);
    end
    idle_cycles(60, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
